// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial add/subtract engine.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } sa_state_t;

    localparam int MAX_WIDTH = 32;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from gate primitives; the only arithmetic in the engine.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    wire ab_x;
    wire ab_a;
    wire c_a;
    wire s_w;
    wire co_w;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s_w, ab_x, cin);
    and g_a0 (ab_a, a, b);
    and g_a1 (c_a, ab_x, cin);
    or  g_o0 (co_w, ab_a, c_a);

    assign s  = s_w;
    assign co = co_w;

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: feeds one full-adder cell LSB-first,
// one bit per clock, with valid/ready handshakes on operands and result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    sa_state_t        state;
    sa_state_t        state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_co;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (bit_s),
        .co  (bit_co)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next           = state;
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = bit_s;
        unique case (state)
            S_IDLE:  if (accept)              state_next = S_ADD;
            S_ADD:   if (last_bit)            state_next = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_next = S_IDLE;
            default:                          state_next = S_IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_sr  <= op_a;
                        // Subtraction is A + ~B + 1: invert B and preload the carry.
                        b_sr  <= sub ? ~op_b : op_b;
                        carry <= sub;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                S_ADD: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= sum_shift;
                    carry <= bit_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout <= bit_co;
                        ovf  <= carry ^ bit_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Scenario bench for serial_adder_ctrl: expected results are queued at accept
// and compared when the engine presents out_valid.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: wide add for carry, sign rules for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0]   full;
        logic [W-1:0] bb;
        res_t         r;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        if (s) r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        else   r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_timeout: out_valid=%b after %0d cycles required 1", out_valid, lat);
        end
    endtask

    // Pops the scoreboard, compares, then completes the output handshake.
    task automatic take_result(input string name);
        res_t r;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: result present but scoreboard empty", name);
        end else begin
            r = exp_q.pop_front();
            if ({sum, cout, ovf} !== r) begin
                n_fail++;
                $display("FAIL %s: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                         name, sum, cout, ovf, r.sum, r.cout, r.ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        int lat;
        send(a, b, s);
        wait_result(lat);
        n_checks++;
        if (lat !== W) begin
            n_fail++;
            $display("FAIL %s_latency: %0d cycles required %0d", name, lat, W);
        end
        take_result(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({out_valid, busy, in_ready, sum, cout, ovf} !== {3'b001, {W{1'b0}}, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b busy=%b in_ready=%b sum=%h cout=%b ovf=%b required 0 0 1 00 0 0",
                     out_valid, busy, in_ready, sum, cout, ovf);
        end
    endtask

    task automatic test_add();
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0);
        run_op("add_rand",  W'($urandom), W'($urandom), 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b1);
        run_op("sub_equal", 8'h3C, 8'h3C, 1'b1);
    endtask

    task automatic test_backpressure();
        int   lat;
        res_t r;
        out_ready = 1'b0;
        send(8'h5A, 8'h33, 1'b0);
        wait_result(lat);
        r = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, r.sum, r.cout, r.ovf}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, ovf, r.sum, r.cout, r.ovf);
            end
        end
        take_result("backpressure");
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        op_a     = 8'h77;
        op_b     = 8'h11;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({busy, out_valid, in_ready, sum} !== {3'b001, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b sum=%h required 0 0 1 00",
                     busy, out_valid, in_ready, sum);
        end
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_result: out_valid seen %0d cycles required 0", seen);
        end
        run_op("after_reset", 8'h01, 8'h01, 1'b0);
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        send(8'h12, 8'h34, 1'b0);
        op_a     = 8'hAA;
        op_b     = 8'h55;
        sub      = 1'b1;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_in_ready: in_ready=%b required 0 during ADD", in_ready);
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_result(lat);
        take_result("ignore_in_valid");
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL ignore_extra: scoreboard holds %0d entries required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int last_acc = -1000;
        int n_acc    = 0;
        int n_res    = 0;
        int lat;
        res_t r;
        op_a      = 8'hC3;
        op_b      = 8'h5E;
        sub       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3 * (W + 2) + 2; cyc++) begin
            if (in_valid && in_ready) begin
                if (n_acc > 0) begin
                    n_checks++;
                    if (cyc - last_acc < W + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: %0d cycles required >= %0d", cyc - last_acc, W + 2);
                    end
                end
                exp_q.push_back(model(op_a, op_b, sub));
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                r = exp_q.pop_front();
                n_res++;
                n_checks++;
                if ({sum, cout, ovf} !== r) begin
                    n_fail++;
                    $display("FAIL b2b_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, r.sum, r.cout, r.ovf);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_res < 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results required >= 2", n_res);
        end
        if (exp_q.size() != 0) begin
            wait_result(lat);
            take_result("b2b_drain");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_mid_reset();
        test_ignore_in_valid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
